// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter that shares the register-file write port
// among NUM_SRC writeback sources. One request is accepted per cycle. It drives
// the write port and the scoreboard busy-clear strobe one cycle after acceptance.
// Optional feature macro: WB_STALL_COUNT_EN builds per-source saturating
// conflict counters on stall_count. Without it, stall_count is tied to zero.
module wb_port_arbiter #(
  parameter int unsigned NUM_SRC          = 3,
  parameter int unsigned THREADS_PER_WARP = 32,
  parameter int unsigned NUM_WARPS        = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_SRC-1:0]                   src_valid,
  output logic [NUM_SRC-1:0]                   src_ready,
  input  logic [NUM_SRC*5-1:0]                 src_addr,
  input  logic [NUM_SRC*6-1:0]                 src_warp_id,
  input  logic [NUM_SRC*THREADS_PER_WARP-1:0]  src_mask,
  input  logic [NUM_SRC*THREADS_PER_WARP*32-1:0] src_data,
  input  logic                                 wb_stall,
  output logic [4:0]                           rd_addr,
  output logic [5:0]                           rd_warp_id,
  output logic [THREADS_PER_WARP-1:0]          rd_thread_mask,
  output logic [THREADS_PER_WARP*32-1:0]       rd_data,
  output logic                                 rd_write_en,
  output logic [4:0]                           clear_busy_reg,
  output logic [5:0]                           clear_busy_warp,
  output logic                                 clear_busy_en,
  output logic [2:0]                           grant_src,
  output logic [NUM_SRC*16-1:0]                stall_count
);

  localparam int unsigned AW = 5;
  localparam int unsigned WW = 6;
  localparam int unsigned MW = THREADS_PER_WARP;
  localparam int unsigned DW = THREADS_PER_WARP * 32;
  localparam int unsigned PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CW = 16;

  // Source index reached by stepping off places forward from base, with wrap-around.
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int unsigned off);
    return PW'((32'(base) + off) % NUM_SRC);
  endfunction

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] sel_idx;
  logic          sel_found;
  logic          xfer;
  logic          warp_ok;

  logic [AW-1:0] sel_addr;
  logic [WW-1:0] sel_warp;
  logic [MW-1:0] sel_mask;
  logic [DW-1:0] sel_data;

  logic [AW-1:0] addr_q, addr_d;
  logic [WW-1:0] warp_q, warp_d;
  logic [MW-1:0] mask_q, mask_d;
  logic [DW-1:0] data_q, data_d;
  logic          wr_en_q, wr_en_d;
  logic          clr_en_q, clr_en_d;
  logic [2:0]    grant_q, grant_d;

  // First valid source at or after rr_ptr. This uses only src_valid, never another source's ready.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!sel_found && src_valid[rr_index(rr_ptr_q, k)]) begin
        sel_found = 1'b1;
        sel_idx   = rr_index(rr_ptr_q, k);
      end
    end
  end

  // One-hot grant, suppressed while stalled or in reset.
  always_comb begin
    src_ready = '0;
    if (sel_found && !wb_stall && !rst) begin
      src_ready[sel_idx] = 1'b1;
    end
  end

  assign xfer     = |(src_valid & src_ready);
  assign sel_addr = src_addr[32'(sel_idx)*AW +: AW];
  assign sel_warp = src_warp_id[32'(sel_idx)*WW +: WW];
  assign sel_mask = src_mask[32'(sel_idx)*MW +: MW];
  assign sel_data = src_data[32'(sel_idx)*DW +: DW];
  assign warp_ok  = ({1'b0, sel_warp} < 7'(NUM_WARPS));

  // Capture the accepted request and form next-cycle strobes. Out-of-range warps are dropped.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    warp_d   = warp_q;
    mask_d   = mask_q;
    data_d   = data_q;
    grant_d  = grant_q;
    wr_en_d  = 1'b0;
    clr_en_d = 1'b0;
    if (xfer) begin
      rr_ptr_d = rr_index(sel_idx, 1);
      grant_d  = 3'(sel_idx);
      if (warp_ok) begin
        addr_d   = sel_addr;
        warp_d   = sel_warp;
        mask_d   = sel_mask;
        data_d   = sel_data;
        clr_en_d = 1'b1;
        wr_en_d  = (sel_addr != '0) && (sel_mask != '0);
      end
    end
  end

  // State and output registers. Reset discards any captured request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      addr_q   <= '0;
      warp_q   <= '0;
      mask_q   <= '0;
      data_q   <= '0;
      grant_q  <= '0;
      wr_en_q  <= 1'b0;
      clr_en_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      warp_q   <= warp_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      wr_en_q  <= wr_en_d;
      clr_en_q <= clr_en_d;
    end
  end

  assign rd_addr         = addr_q;
  assign rd_warp_id      = warp_q;
  assign rd_thread_mask  = mask_q;
  assign rd_data         = data_q;
  assign rd_write_en     = wr_en_q;
  assign clear_busy_reg  = addr_q;
  assign clear_busy_warp = warp_q;
  assign clear_busy_en   = clr_en_q;
  assign grant_src       = grant_q;

`ifdef WB_STALL_COUNT_EN
  logic [NUM_SRC*CW-1:0] stall_cnt_q, stall_cnt_d;

  // Count cycles a source waits with valid high but no grant, saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && !src_ready[i] && (stall_cnt_q[i*CW +: CW] != '1)) begin
        stall_cnt_d[i*CW +: CW] = stall_cnt_q[i*CW +: CW] + CW'(1);
      end
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter. The stimulus side predicts grants and strobes from the
// round-robin rules and queues them. The monitor compares the registered outputs.
module tb_wb_port_arbiter;

  localparam int unsigned N   = 3;
  localparam int unsigned TPW = 32;
  localparam int unsigned NW  = 8;
  localparam int unsigned DW  = TPW * 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      src_valid;
  logic [N-1:0]      src_ready;
  logic [N*5-1:0]    src_addr;
  logic [N*6-1:0]    src_warp_id;
  logic [N*TPW-1:0]  src_mask;
  logic [N*DW-1:0]   src_data;
  logic              wb_stall;
  logic [4:0]        rd_addr;
  logic [5:0]        rd_warp_id;
  logic [TPW-1:0]    rd_thread_mask;
  logic [DW-1:0]     rd_data;
  logic              rd_write_en;
  logic [4:0]        clear_busy_reg;
  logic [5:0]        clear_busy_warp;
  logic              clear_busy_en;
  logic [2:0]        grant_src;
  logic [N*16-1:0]   stall_count;

  wb_port_arbiter #(.NUM_SRC(N), .THREADS_PER_WARP(TPW), .NUM_WARPS(NW)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_warp_id(src_warp_id),
    .src_mask(src_mask), .src_data(src_data),
    .wb_stall(wb_stall),
    .rd_addr(rd_addr), .rd_warp_id(rd_warp_id),
    .rd_thread_mask(rd_thread_mask), .rd_data(rd_data),
    .rd_write_en(rd_write_en),
    .clear_busy_reg(clear_busy_reg), .clear_busy_warp(clear_busy_warp),
    .clear_busy_en(clear_busy_en),
    .grant_src(grant_src), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             xfer;
    int             grant;
    bit             wr;
    bit             clr;
    logic [4:0]     addr;
    logic [5:0]     warp;
    logic [TPW-1:0] mask;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Staged requests, applied at the next falling edge by step().
  logic [N-1:0]   nv;
  bit             nstall;
  logic [4:0]     naddr[N];
  logic [5:0]     nwarp[N];
  logic [TPW-1:0] nmask[N];
  logic [DW-1:0]  ndata[N];

  // Reference state: rotating priority pointer and per-source wait counters.
  int          ptr;
  int unsigned cnt[N];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic set_src(input int i, input logic [4:0] a, input logic [5:0] w,
                         input logic [TPW-1:0] m, input logic [31:0] base);
    naddr[i] = a;
    nwarp[i] = w;
    nmask[i] = m;
    for (int j = 0; j < TPW; j++) ndata[i][j*32 +: 32] = base + 32'(j);
  endtask

  // Apply one cycle of stimulus, check the combinational grant, and queue the expected result.
  task automatic step();
    int           g;
    logic [N-1:0] er;
    exp_t         e;
    @(negedge clk);
    src_valid = nv;
    wb_stall  = nstall;
    for (int i = 0; i < N; i++) begin
      src_addr[i*5 +: 5]       = naddr[i];
      src_warp_id[i*6 +: 6]    = nwarp[i];
      src_mask[i*TPW +: TPW]   = nmask[i];
      src_data[i*DW +: DW]     = ndata[i];
    end
    #1;
    g = -1;
    if (!nstall) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && nv[(ptr + k) % N]) g = (ptr + k) % N;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("src_ready", 64'(src_ready), 64'(er));
    for (int i = 0; i < N; i++) begin
      if (nv[i] && !er[i] && cnt[i] < 65535) cnt[i]++;
    end
    e.xfer = 1'b0; e.grant = 0; e.wr = 1'b0; e.clr = 1'b0;
    e.addr = '0; e.warp = '0; e.mask = '0; e.data = '0;
    if (g >= 0) begin
      e.xfer  = 1'b1;
      e.grant = g;
      e.clr   = (int'(nwarp[g]) < NW);
      e.wr    = e.clr && (naddr[g] != 0) && (nmask[g] != 0);
      e.addr  = naddr[g];
      e.warp  = nwarp[g];
      e.mask  = nmask[g];
      e.data  = ndata[g];
      ptr     = (g + 1) % N;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    nv = '0;
    nstall = 1'b0;
    step();
  endtask

  task automatic chk_cnt();
    logic [N*16-1:0] ex;
    ex = '0;
`ifdef WB_STALL_COUNT_EN
    for (int i = 0; i < N; i++) ex[i*16 +: 16] = 16'(cnt[i]);
`endif
    chk("stall_count", 64'(stall_count), 64'(ex));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd_write_en"}, 64'(rd_write_en), 64'd0);
    chk({tag, "_clear_busy_en"}, 64'(clear_busy_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_rd_warp_id"}, 64'(rd_warp_id), 64'd0);
    chk({tag, "_rd_thread_mask"}, 64'(rd_thread_mask), 64'd0);
    chk({tag, "_rd_data_zero"}, 64'(rd_data != '0), 64'd0);
    chk({tag, "_grant_src"}, 64'(grant_src), 64'd0);
    chk({tag, "_stall_count"}, 64'(stall_count), 64'd0);
  endtask

  task automatic model_reset();
    ptr = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    nv = '0;
    nstall = 1'b0;
  endtask

  // Full reset with hold_valid presented during reset; grants must stay off.
  task automatic do_reset(input logic [N-1:0] hold_valid);
    @(negedge clk);
    src_valid = hold_valid;
    wb_stall  = 1'b0;
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("reset_src_ready", 64'(src_ready), 64'd0);
    chk_zero_outputs("reset");
    @(negedge clk);
    src_valid = '0;
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compare the registered port against the queued prediction every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_write_en", 64'(rd_write_en), 64'(e.wr));
        chk("clear_busy_en", 64'(clear_busy_en), 64'(e.clr));
        if (e.xfer) chk("grant_src", 64'(grant_src), 64'(e.grant));
        if (e.clr) begin
          chk("rd_addr", 64'(rd_addr), 64'(e.addr));
          chk("rd_warp_id", 64'(rd_warp_id), 64'(e.warp));
          chk("clear_busy_reg", 64'(clear_busy_reg), 64'(e.addr));
          chk("clear_busy_warp", 64'(clear_busy_warp), 64'(e.warp));
          chk("rd_thread_mask", 64'(rd_thread_mask), 64'(e.mask));
          checks++;
          if (rd_data !== e.data) begin
            errors++;
            for (int j = 0; j < TPW; j++) begin
              if (rd_data[j*32 +: 32] !== e.data[j*32 +: 32]) begin
                $display("FAIL rd_data lane %0d got %h expected %h at %0t",
                         j, rd_data[j*32 +: 32], e.data[j*32 +: 32], $time);
                break;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    src_valid = '0; wb_stall = 1'b0;
    src_addr = '0; src_warp_id = '0; src_mask = '0; src_data = '0;
    model_reset();
    for (int i = 0; i < N; i++) set_src(i, 5'd0, 6'd0, '0, 32'd0);
    #2 rst = 1'b1;

    // Reset state, with all sources requesting during reset.
    do_reset(3'b111);

    // Single source request.
    nv = 3'b001;
    set_src(0, 5'd5, 6'd0, '1, 32'hA000_0000);
    step();
    idle();

    // Fairness from reset: all sources hold valid.
    do_reset('0);
    set_src(0, 5'd1, 6'd1, '1, 32'h1000_0000);
    set_src(1, 5'd2, 6'd2, 32'h0000_FFFF, 32'h2000_0000);
    set_src(2, 5'd3, 6'd3, 32'hFFFF_0000, 32'h3000_0000);
    nv = 3'b111;
    repeat (6) step();
    idle();
    chk_cnt();

    // Suppressed writes: zero register, empty mask, out-of-range warp.
    nv = 3'b001;
    set_src(0, 5'd0, 6'd0, '1, 32'h4000_0000);
    step();
    set_src(0, 5'd10, 6'd1, 32'h0, 32'h5000_0000);
    step();
    set_src(0, 5'd7, 6'd9, '1, 32'h6000_0000);
    step();
    set_src(0, 5'd31, 6'd7, 32'h8000_0001, 32'h7000_0000);
    step();
    idle();

    // Stall holds off grants; counters see the waiting source.
    do_reset('0);
    nv = 3'b010;
    set_src(1, 5'd12, 6'd4, '1, 32'h8000_0000);
    nstall = 1'b1;
    repeat (4) step();
    nstall = 1'b0;
    step();
    idle();
    chk_cnt();

    // Stall rising alongside a request: the previous capture still strobes.
    nv = 3'b001;
    set_src(0, 5'd9, 6'd2, '1, 32'h9000_0000);
    step();
    nstall = 1'b1;
    step();
    idle();

    // Reset in flight: the captured request never strobes.
    nv = 3'b011;
    set_src(0, 5'd4, 6'd0, '1, 32'hB000_0000);
    set_src(1, 5'd6, 6'd1, '1, 32'hC000_0000);
    step();
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk_zero_outputs("midreset");
    @(negedge clk);
    src_valid = '0;
    #1 rst = 1'b0;
    model_reset();
    nv = 3'b011;
    step();
    step();
    idle();

    // Back-to-back alternating sources 0 and 2.
    set_src(0, 5'd14, 6'd5, '1, 32'hD000_0000);
    set_src(2, 5'd15, 6'd6, '1, 32'hE000_0000);
    for (int c = 0; c < 8; c++) begin
      nv = (c % 2 == 0) ? 3'b001 : 3'b100;
      step();
    end
    idle();

    // Randomized traffic.
    do_reset('0);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        nv[i] = ($urandom_range(0, 3) != 0);
        set_src(i,
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                6'($urandom_range(0, 11)),
                ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom),
                32'($urandom));
      end
      nstall = ($urandom_range(0, 7) == 0);
      step();
    end
    idle();
    chk_cnt();

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
